mips32_mem_arbiter: RTL and testbench

- Single-port arbiter/sequencer for the unified MIPS32 instruction/data memory.
- Shares one memory port between the IF stage (instruction fetch) and the MEM stage (load/store).
- Issues one access at a time, waits a fixed memory latency, then returns read data to the winning requester.
- Sits between the pipeline stage registers and the memory array. Blocks new fetches once the core is halted.

---
 rtl/mips32_arb_pkg.sv | 21 ++
 rtl/mips32_arb_prio.sv | 36 +++
 rtl/mips32_mem_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_mips32_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips32_arb_pkg.sv
// Shared types and default widths for the MIPS32 unified-memory arbiter.
package mips32_arb_pkg;

    localparam int unsigned ARB_AW   = 32;
    localparam int unsigned ARB_DW   = 32;
    localparam int unsigned STREAK_W = 4;
    localparam int unsigned CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/mips32_arb_prio.sv
// Combinational fetch/data priority pick with anti-starvation streak limit.
module mips32_arb_prio
    import mips32_arb_pkg::*;
#(
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic                if_req,
    input  logic                dm_req,
    input  logic                halted,
    input  logic [STREAK_W-1:0] streak,
    output logic                win_valid_c,
    output arb_owner_e          win_owner_c,
    output logic [STREAK_W-1:0] streak_nxt_c
);

    logic if_el;

    // Data wins unless fetch is alone or has waited through MAX_STREAK data grants
    always_comb begin
        if_el        = if_req && !halted;
        win_valid_c  = 1'b0;
        win_owner_c  = OWN_IF;
        streak_nxt_c = if_el ? streak : '0;
        if (dm_req && !(if_el && (streak == STREAK_W'(MAX_STREAK)))) begin
            win_valid_c  = 1'b1;
            win_owner_c  = OWN_DM;
            // streak < MAX_STREAK here, so the increment cannot pass the limit
            streak_nxt_c = if_el ? (streak + STREAK_W'(1)) : '0;
        end else if (if_el) begin
            win_valid_c  = 1'b1;
            win_owner_c  = OWN_IF;
            streak_nxt_c = '0;
        end
    end

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Single-port IF/MEM arbiter for the unified MIPS32 memory.
// Optional performance counters: define MIPS32_ARB_PERF_EN.
module mips32_mem_arbiter
    import mips32_arb_pkg::*;
#(
    parameter int unsigned AW         = ARB_AW,
    parameter int unsigned DW         = ARB_DW,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    input  logic          halted,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
`ifdef MIPS32_ARB_PERF_EN
    ,
    output logic [31:0]   perf_if_stall,
    output logic [31:0]   perf_dm_stall,
    output logic [31:0]   perf_starve_ovr
`endif
);

    arb_state_e          state_q, state_d;
    arb_owner_e          owner_q, owner_d;
    logic                store_q, store_d;
    logic [CNT_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                if_gnt_q, if_gnt_d, dm_gnt_q, dm_gnt_d;
    logic                if_rvalid_q, if_rvalid_d, dm_rvalid_q, dm_rvalid_d;
    logic [DW-1:0]       if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
    logic                mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [AW-1:0]       mem_addr_q, mem_addr_d;
    logic [DW-1:0]       mem_wdata_q, mem_wdata_d;
    logic                busy_q, busy_d;

    logic                if_el_c;
    logic                resp_now_c;
    logic                win_valid_c;
    arb_owner_e          win_owner_c;
    logic [STREAK_W-1:0] streak_nxt_c;

    assign if_el_c = if_req && !halted;

    mips32_arb_prio #(
        .MAX_STREAK (MAX_STREAK)
    ) u_prio (
        .if_req       (if_req),
        .dm_req       (dm_req),
        .halted       (halted),
        .streak       (streak_q),
        .win_valid_c  (win_valid_c),
        .win_owner_c  (win_owner_c),
        .streak_nxt_c (streak_nxt_c)
    );

    // Next-state and next-output logic; outputs for a state are computed on entry
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        store_d     = store_q;
        lat_cnt_d   = lat_cnt_q;
        streak_d    = if_el_c ? streak_q : '0;
        if_gnt_d    = 1'b0;
        dm_gnt_d    = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rvalid_d = 1'b0;
        dm_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        resp_now_c  = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                streak_d = streak_nxt_c;
                if (win_valid_c) begin
                    state_d  = ISSUE;
                    owner_d  = win_owner_c;
                    mem_en_d = 1'b1;
                    if (win_owner_c == OWN_DM) begin
                        dm_gnt_d    = 1'b1;
                        store_d     = dm_we;
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                    end else begin
                        if_gnt_d   = 1'b1;
                        store_d    = 1'b0;
                        mem_addr_d = if_addr;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (MEM_LAT > 1) begin
                    state_d   = WAIT;
                    lat_cnt_d = CNT_W'(MEM_LAT - 2);
                end else begin
                    state_d    = RESP;
                    resp_now_c = 1'b1;
                end
            end
            WAIT: begin
                if (lat_cnt_q == '0) begin
                    state_d    = RESP;
                    resp_now_c = 1'b1;
                end else begin
                    lat_cnt_d = lat_cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // mem_rdata is captured on the edge that enters RESP
        if (resp_now_c) begin
            if (owner_q == OWN_IF) begin
                if_rvalid_d = 1'b1;
                if_rdata_d  = mem_rdata;
            end else begin
                dm_rvalid_d = 1'b1;
                dm_rdata_d  = store_q ? '0 : mem_rdata;
            end
        end
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            store_q     <= 1'b0;
            lat_cnt_q   <= '0;
            streak_q    <= '0;
            if_gnt_q    <= 1'b0;
            dm_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            store_q     <= store_d;
            lat_cnt_q   <= lat_cnt_d;
            streak_q    <= streak_d;
            if_gnt_q    <= if_gnt_d;
            dm_gnt_q    <= dm_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            dm_rvalid_q <= dm_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign dm_gnt    = dm_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign dm_rvalid = dm_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

`ifdef MIPS32_ARB_PERF_EN
    logic [31:0] perf_if_stall_q, perf_if_stall_d;
    logic [31:0] perf_dm_stall_q, perf_dm_stall_d;
    logic [31:0] perf_starve_ovr_q, perf_starve_ovr_d;

    // Stall and forced-fetch event counters, wrapping modulo 2^32
    always_comb begin
        perf_if_stall_d   = perf_if_stall_q;
        perf_dm_stall_d   = perf_dm_stall_q;
        perf_starve_ovr_d = perf_starve_ovr_q;
        if (if_el_c && !if_gnt_q) begin
            perf_if_stall_d = perf_if_stall_q + 32'd1;
        end
        if (dm_req && !dm_gnt_q) begin
            perf_dm_stall_d = perf_dm_stall_q + 32'd1;
        end
        // fetch beating a live data request can only be the streak override
        if (((state_q == IDLE) || (state_q == RESP)) && win_valid_c &&
            (win_owner_c == OWN_IF) && dm_req) begin
            perf_starve_ovr_d = perf_starve_ovr_q + 32'd1;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            perf_if_stall_q   <= '0;
            perf_dm_stall_q   <= '0;
            perf_starve_ovr_q <= '0;
        end else begin
            perf_if_stall_q   <= perf_if_stall_d;
            perf_dm_stall_q   <= perf_dm_stall_d;
            perf_starve_ovr_q <= perf_starve_ovr_d;
        end
    end

    assign perf_if_stall   = perf_if_stall_q;
    assign perf_dm_stall   = perf_dm_stall_q;
    assign perf_starve_ovr = perf_starve_ovr_q;
`endif

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Bench for mips32_mem_arbiter: directed scenarios followed by random traffic,
// checked every cycle against a timeline-based reference model.
`timescale 1ns/1ps
module tb_mips32_mem_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned LAT  = 3;
    localparam int unsigned MAXS = 4;

    logic          clk1 = 1'b0;
    logic          rst_n;
    logic          if_req, dm_req, dm_we, halted;
    logic [AW-1:0] if_addr, dm_addr;
    logic [DW-1:0] dm_wdata, mem_rdata;
    logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid;
    logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
    logic          mem_en, mem_we, busy;
    logic [AW-1:0] mem_addr;
`ifdef MIPS32_ARB_PERF_EN
    logic [31:0]   perf_if_stall, perf_dm_stall, perf_starve_ovr;
`endif

    always #5 clk1 = ~clk1;

    mips32_mem_arbiter #(
        .AW (AW), .DW (DW), .MEM_LAT (LAT), .MAX_STREAK (MAXS)
    ) dut (
        .clk1 (clk1), .rst_n (rst_n),
        .if_req (if_req), .if_addr (if_addr), .if_gnt (if_gnt),
        .if_rvalid (if_rvalid), .if_rdata (if_rdata),
        .dm_req (dm_req), .dm_we (dm_we), .dm_addr (dm_addr), .dm_wdata (dm_wdata),
        .dm_gnt (dm_gnt), .dm_rvalid (dm_rvalid), .dm_rdata (dm_rdata),
        .halted (halted),
        .mem_en (mem_en), .mem_we (mem_we), .mem_addr (mem_addr),
        .mem_wdata (mem_wdata), .mem_rdata (mem_rdata), .busy (busy)
`ifdef MIPS32_ARB_PERF_EN
        , .perf_if_stall (perf_if_stall), .perf_dm_stall (perf_dm_stall),
        .perf_starve_ovr (perf_starve_ovr)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // memory environment
    logic [31:0] ram [16];
    int          env_cnt;
    logic [3:0]  env_addr;

    // reference model: access timeline and expected outputs for the coming cycle
    logic [31:0] ref_ram [16];
    int          m_resp_at, m_rv_at, m_streak;
    logic        m_rv_dm;
    logic [31:0] m_rv_data;
    logic        e_if_gnt, e_dm_gnt, e_if_rv, e_dm_rv, e_mem_en, e_mem_we, e_busy;
    logic [31:0] e_if_rdata, e_dm_rdata, e_mem_addr, e_mem_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_streak = 0; m_resp_at = -1; m_rv_at = -1; m_rv_dm = 1'b0; m_rv_data = '0;
        e_if_gnt = 0; e_dm_gnt = 0; e_if_rv = 0; e_dm_rv = 0;
        e_mem_en = 0; e_mem_we = 0; e_busy = 0;
        e_if_rdata = '0; e_dm_rdata = '0; e_mem_addr = '0; e_mem_wdata = '0;
        env_cnt = 0;
    endtask

    // Uses inputs of the current cycle to predict outputs after the next edge
    task automatic predict();
        logic if_el;
        logic dm_win, if_win;
        logic [31:0] a;
        e_if_gnt = 0; e_dm_gnt = 0; e_if_rv = 0; e_dm_rv = 0; e_mem_en = 0; e_mem_we = 0;
        if (cyc + 1 == m_rv_at) begin
            if (m_rv_dm) begin e_dm_rv = 1; e_dm_rdata = m_rv_data; end
            else begin e_if_rv = 1; e_if_rdata = m_rv_data; end
        end
        if_el  = if_req && !halted;
        dm_win = 0;
        if_win = 0;
        if (cyc >= m_resp_at) begin
            if (dm_req && !(if_el && m_streak == int'(MAXS))) dm_win = 1;
            else if (if_el) if_win = 1;
        end
        if (dm_win) begin
            m_streak = if_el ? ((m_streak + 1 > int'(MAXS)) ? int'(MAXS) : m_streak + 1) : 0;
            a = dm_addr;
            e_dm_gnt = 1; e_mem_en = 1; e_mem_we = dm_we;
            e_mem_addr = a; e_mem_wdata = dm_wdata;
            m_rv_dm = 1;
            m_rv_data = dm_we ? 32'd0 : ref_ram[a[3:0]];
            if (dm_we) ref_ram[a[3:0]] = dm_wdata;
        end else if (if_win) begin
            m_streak = 0;
            a = if_addr;
            e_if_gnt = 1; e_mem_en = 1; e_mem_addr = a;
            m_rv_dm = 0;
            m_rv_data = ref_ram[a[3:0]];
        end else if (!if_el) begin
            m_streak = 0;
        end
        if (dm_win || if_win) begin
            m_resp_at = cyc + 1 + int'(LAT);
            m_rv_at   = m_resp_at;
        end
        e_busy = (cyc + 1 <= m_resp_at);
    endtask

    task automatic check_all();
        chk("if_gnt",    32'(if_gnt),    32'(e_if_gnt));
        chk("dm_gnt",    32'(dm_gnt),    32'(e_dm_gnt));
        chk("if_rvalid", 32'(if_rvalid), 32'(e_if_rv));
        chk("dm_rvalid", 32'(dm_rvalid), 32'(e_dm_rv));
        chk("if_rdata",  if_rdata,       e_if_rdata);
        chk("dm_rdata",  dm_rdata,       e_dm_rdata);
        chk("mem_en",    32'(mem_en),    32'(e_mem_en));
        chk("mem_we",    32'(mem_we),    32'(e_mem_we));
        chk("mem_addr",  mem_addr,       e_mem_addr);
        chk("mem_wdata", mem_wdata,      e_mem_wdata);
        chk("busy",      32'(busy),      32'(e_busy));
    endtask

    // Memory responds only in the cycle whose closing edge is LAT cycles after mem_en
    task automatic mem_env();
        if (mem_en) begin
            env_cnt  = 1;
            env_addr = mem_addr[3:0];
            if (mem_we) ram[env_addr] = mem_wdata;
        end else if (env_cnt > 0) begin
            env_cnt++;
        end
        mem_rdata = (env_cnt == int'(LAT)) ? ram[env_addr] : $urandom();
    endtask

    task automatic step();
        predict();
        @(posedge clk1);
        #1;
        cyc++;
        check_all();
        mem_env();
    endtask

    task automatic drain(input int n);
        repeat (n) step();
    endtask

    task automatic wait_gnt(input bit is_dm, input string tag);
        int k = 0;
        while (k < 40 && !(is_dm ? dm_gnt : if_gnt)) begin
            step();
            k++;
        end
        chk(tag, 32'(k < 40), 32'd1);
    endtask

    // Random requester behaviour honouring hold-until-grant, with rare withdrawals
    task automatic traffic();
        if (if_req && if_gnt) begin
            if_req = ($urandom_range(0, 1) == 1);
            if_addr = $urandom();
        end else if (!if_req && $urandom_range(0, 2) == 0) begin
            if_req = 1; if_addr = $urandom();
        end else if (if_req && $urandom_range(0, 31) == 0) begin
            if_req = 0;
        end
        if (dm_req && dm_gnt) begin
            dm_req = ($urandom_range(0, 1) == 1);
            dm_we = $urandom_range(0, 1) == 1; dm_addr = $urandom(); dm_wdata = $urandom();
        end else if (!dm_req && $urandom_range(0, 2) == 0) begin
            dm_req = 1;
            dm_we = $urandom_range(0, 1) == 1; dm_addr = $urandom(); dm_wdata = $urandom();
        end else if (dm_req && $urandom_range(0, 31) == 0) begin
            dm_req = 0;
        end
        if ($urandom_range(0, 19) == 0) halted = ~halted;
    endtask

    initial begin
        int dm_cnt;
        bit seen_if;
        rst_n = 0; if_req = 0; dm_req = 0; dm_we = 0; halted = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
        for (int i = 0; i < 16; i++) begin
            ram[i] = $urandom();
            ref_ram[i] = ram[i];
        end
        ram[3] = 32'h0ce77800;
        ref_ram[3] = 32'h0ce77800;
        model_reset();
        repeat (2) @(posedge clk1);
        #1;
        check_all();
        rst_n = 1;

        // fetch only
        if_req = 1; if_addr = 32'd3;
        wait_gnt(0, "fetch_only_timeout");
        if_req = 0;
        drain(LAT + 2);

        // simultaneous fetch and load: data first, fetch next
        if_req = 1; if_addr = 32'd7;
        dm_req = 1; dm_we = 0; dm_addr = 32'd5;
        wait_gnt(1, "both_dm_timeout");
        dm_req = 0;
        wait_gnt(0, "both_if_timeout");
        if_req = 0;
        drain(LAT + 2);

        // data stream with a waiting fetch: streak limit forces one fetch
        if_req = 1; if_addr = 32'd9;
        dm_req = 1; dm_we = 0; dm_addr = 32'd1;
        dm_cnt = 0; seen_if = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (dm_gnt) begin
                if (!seen_if) dm_cnt++;
                dm_we = $urandom_range(0, 1) == 1;
                dm_addr = 32'($urandom_range(0, 15));
                dm_wdata = $urandom();
            end
            if (if_gnt) begin
                seen_if = 1;
                if_req = 0;
            end
        end
        chk("streak_dm_grants", 32'(dm_cnt), 32'(MAXS));
        chk("streak_if_granted", 32'(seen_if), 32'd1);
        dm_req = 0;
        drain(LAT + 2);

        // store then load back
        dm_req = 1; dm_we = 1; dm_addr = 32'd8; dm_wdata = 32'h00000019;
        wait_gnt(1, "store_timeout");
        dm_req = 0;
        drain(LAT + 1);
        dm_req = 1; dm_we = 0; dm_addr = 32'd8;
        wait_gnt(1, "load_timeout");
        dm_req = 0;
        drain(LAT + 2);

        // halted rises while a fetch is in flight
        if_req = 1; if_addr = 32'd4;
        wait_gnt(0, "halt_fetch_timeout");
        if_addr = 32'd6;
        step();
        halted = 1;
        drain(8);
        dm_req = 1; dm_we = 0; dm_addr = 32'd3;
        wait_gnt(1, "halt_dm_timeout");
        dm_req = 0;
        drain(LAT + 2);
        halted = 0;
        wait_gnt(0, "unhalt_fetch_timeout");
        if_req = 0;
        drain(LAT + 2);

        // asynchronous reset during WAIT
        if_req = 1; if_addr = 32'd2;
        wait_gnt(0, "rst_fetch_timeout");
        if_req = 0;
        step();
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check_all();
        @(posedge clk1);
        #1;
        cyc++;
        check_all();
        rst_n = 1;
        mem_rdata = $urandom();
        drain(LAT + 2);
        if_req = 1; if_addr = 32'd3;
        wait_gnt(0, "post_rst_timeout");
        if_req = 0;
        drain(LAT + 2);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step();
            traffic();
        end
        if_req = 0; dm_req = 0;
        drain(LAT + 3);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
